image_frame_scheduler: RTL and testbench
========================================

IMAGE_FRAME_SCHEDULER -- requirements
Module: image_frame_scheduler

Interface
REQ-001 SHALL have parameter FRAME_WIDTH, default 2200: pixels per line including blanking.
REQ-002 SHALL have parameter FRAME_HEIGHT, default 1125: lines per frame including blanking.
REQ-003 SHALL have parameters BIT_WIDTH = 12 and BIT_HEIGHT = 11, the widths of cx and cy.
REQ-004 SHALL have one clock and a synchronous, active-low reset, as follows:
- clk_pixel  in  1  sole clock; all logic is rising-edge.
- clk_pixel_resetn  in  1  synchronous, active-low reset.
REQ-005 SHALL have the following signal ports:
- counter  in  64  global timestamp, clk_pixel domain, monotonic.
- cx  in  BIT_WIDTH  current pixel column.
- cy  in  BIT_HEIGHT  current pixel line.
- cmd_dout  in  128  command FIFO head word (first-word-fall-through).
- cmd_empty  in  1  command FIFO empty.
- cmd_rd_en  out  1  one-cycle pop of the command FIFO.
- image_empty  in  1  pixel FIFO of the image sender is empty.
- auto_start  out  1  one-cycle start pulse to the image sender.
- image_flush  out  1  one-cycle flush pulse to the image sender.
- image_reset  out  1  one-cycle reset pulse to the image sender.
- sched_enable  in  1  permits command fetch.
- flag_clear  in  1  clears the sticky flags and the counter.
- busy  out  1  high whenever the state is not IDLE.
- late_flag  out  1  sticky: a command's start_time had already passed when it was evaluated.
- error_flag  out  1  sticky: an unknown opcode was received.
- underrun_count  out  16  count of frames lost to underrun, saturating.

Function
REQ-006 Command word fields SHALL be:
- [63:0] start_time.
- [79:64] frame_count.
- [81:80] opcode: 0 SHOW, 1 FLUSH, 2 RESET_SENDER, 3 reserved.
- [127:82] ignored.
REQ-007 The state machine SHALL have the states IDLE, DECODE, WAIT_TIME, WAIT_FRAME and DISPLAY.
REQ-008 In IDLE, when sched_enable=1 and cmd_empty=0, the block SHALL:
- assert cmd_rd_en for exactly one cycle;
- latch cmd_dout in the same cycle;
- move to DECODE on the next cycle.
REQ-009 DECODE SHALL last one cycle and act on the opcode:
- SHOW: go to WAIT_TIME.
- FLUSH: pulse image_flush for one cycle, then go to IDLE.
- RESET_SENDER: pulse image_reset for one cycle, then go to IDLE.
- reserved: set error_flag, then go to IDLE.
REQ-010 WAIT_TIME SHALL compare counter >= start_time as an unsigned 64-bit compare and go to WAIT_FRAME on the first cycle it is true.
REQ-011 If that compare is already true on the first WAIT_TIME cycle, the block SHALL set late_flag and still proceed.
REQ-012 Frame start SHALL be defined as cx==0 && cy==0; frame end SHALL be defined as cx==FRAME_WIDTH-1 && cy==FRAME_HEIGHT-1.
REQ-013 In WAIT_FRAME, on a frame-start cycle:
- if image_empty=0, assert auto_start combinationally in that same cycle (zero latency), load frames_left with max(frame_count,1), and go to DISPLAY;
- if image_empty=1, increment underrun_count (saturating at 16'hFFFF) and keep waiting for the next frame start.
REQ-014 In DISPLAY, on each frame-end cycle, frames_left SHALL decrement.
REQ-015 DISPLAY SHALL go to IDLE at the frame end where frames_left was 1, with one exception: when frame_count==0, the block SHALL hold in DISPLAY until a frame end with cmd_empty=0.
REQ-016 A new command SHALL never be popped before the frame end that terminates DISPLAY, so image switches occur only at frame boundaries.
REQ-017 sched_enable=0 SHALL only block fetch in IDLE; a command already fetched SHALL run to completion.
REQ-018 When flag_clear and a flag-setting event occur in the same cycle, the event SHALL win: the flag ends set, and the counter ends at 1.
REQ-019 auto_start, image_flush, image_reset and cmd_rd_en SHALL never be high in the same cycle, and each SHALL be high for at most one cycle per command.
REQ-020 counter wrap-around SHALL NOT be handled; 64-bit time is treated as non-wrapping.

Reset
REQ-021 While clk_pixel_resetn=0 at a rising edge, the block SHALL:
- set the state to IDLE;
- drive all pulse outputs to 0 and busy to 0;
- clear late_flag, error_flag and underrun_count to 0;
- clear frames_left and the latched command to 0.
REQ-022 Reset mid-operation SHALL:
- abandon the current command without emitting any pulse;
- leave any already-popped command unrecovered.
REQ-023 The first fetch after reset SHALL be possible on the first cycle with clk_pixel_resetn=1.

Structure
REQ-024 A shared package image_sched_pkg SHALL hold:
- the opcode enum;
- the state enum;
- the command field bit positions (TIME_LSB/MSB, COUNT_LSB/MSB, OP_LSB/MSB).
REQ-025 The block SHALL be a single module with no sub-module; the frame-start and frame-end decode are two local compares.

Verification
REQ-026 Scenario: SHOW, start_time=1000, frame_count=2, image_empty=0, counter starts at 0.
Required: no auto_start before counter=1000; one auto_start at the next cx=0,cy=0; IDLE after the 2nd frame end; late_flag=0.
REQ-027 Scenario: SHOW, start_time=5, issued with counter=500.
Required: late_flag=1 after the first WAIT_TIME cycle; auto_start at the next frame start.
REQ-028 Scenario: image_empty=1 for 3 frame starts, then 0.
Required: underrun_count=3; auto_start on the 4th frame start.
REQ-029 Scenario: FLUSH, then RESET_SENDER, then opcode 3, queued back-to-back.
Required: image_flush and image_reset pulses each exactly one cycle and separated in time; error_flag=1; no auto_start.
REQ-030 Scenario: SHOW with frame_count=0, then a second SHOW queued after 3 frames.
Required: DISPLAY holds; the second command is popped at the first frame end after cmd_empty goes 0.
REQ-031 Scenario: reset asserted in WAIT_FRAME, plus flag_clear asserted in the same cycle as an underrun.
Required: after reset, every output is 0; with flag_clear coincident with the underrun, underrun_count=1.

Source files
------------

// File: rtl/image_frame_scheduler_pkg.sv
// rtl/image_frame_scheduler_pkg.sv - shared types and command field layout for the frame scheduler
package image_sched_pkg;

    typedef enum logic [1:0] {
        OP_SHOW         = 2'd0,
        OP_FLUSH        = 2'd1,
        OP_RESET_SENDER = 2'd2,
        OP_RESERVED     = 2'd3
    } opcode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_WAIT_TIME,
        ST_WAIT_FRAME,
        ST_DISPLAY
    } state_e;

    localparam int CMD_WIDTH = 128;
    localparam int TIME_LSB  = 0;
    localparam int TIME_MSB  = 63;
    localparam int COUNT_LSB = 64;
    localparam int COUNT_MSB = 79;
    localparam int OP_LSB    = 80;
    localparam int OP_MSB    = 81;

endpackage

// File: rtl/image_frame_scheduler_if.sv
// rtl/image_frame_scheduler_if.sv - command FIFO and image sender handshake bundle
interface image_frame_scheduler_if;
    import image_sched_pkg::*;

    logic [CMD_WIDTH-1:0] cmd_dout;
    logic                 cmd_empty;
    logic                 cmd_rd_en;
    logic                 image_empty;
    logic                 auto_start;
    logic                 image_flush;
    logic                 image_reset;

    modport master (
        input  cmd_dout,
        input  cmd_empty,
        input  image_empty,
        output cmd_rd_en,
        output auto_start,
        output image_flush,
        output image_reset
    );

    modport slave (
        output cmd_dout,
        output cmd_empty,
        output image_empty,
        input  cmd_rd_en,
        input  auto_start,
        input  image_flush,
        input  image_reset
    );
endinterface

// File: rtl/image_frame_scheduler.sv
// rtl/image_frame_scheduler.sv - timestamped command scheduler that starts image playback on frame boundaries
module image_frame_scheduler
    import image_sched_pkg::*;
#(
    parameter int FRAME_WIDTH  = 2200,
    parameter int FRAME_HEIGHT = 1125,
    parameter int BIT_WIDTH    = 12,
    parameter int BIT_HEIGHT   = 11
) (
    input  logic                   clk_pixel,
    input  logic                   clk_pixel_resetn,
    input  logic [63:0]            counter,
    input  logic [BIT_WIDTH-1:0]   cx,
    input  logic [BIT_HEIGHT-1:0]  cy,
    image_frame_scheduler_if.master bus,
    input  logic                   sched_enable,
    input  logic                   flag_clear,
    output logic                   busy,
    output logic                   late_flag,
    output logic                   error_flag,
    output logic [15:0]            underrun_count
);

    state_e          state;
    logic [OP_MSB:0] cmd;
    logic [15:0]     frames_left;
    logic            wait_first;

    logic [63:0] start_time;
    logic [15:0] frame_count;
    opcode_e     opcode;

    assign start_time  = cmd[TIME_MSB:TIME_LSB];
    assign frame_count = cmd[COUNT_MSB:COUNT_LSB];
    assign opcode      = opcode_e'(cmd[OP_MSB:OP_LSB]);

    wire unused_cmd_bits = ^bus.cmd_dout[CMD_WIDTH-1:OP_MSB+1];

    logic frame_start, frame_end, time_reached;
    assign frame_start  = (cx == '0) && (cy == '0);
    assign frame_end    = (cx == BIT_WIDTH'(FRAME_WIDTH - 1)) && (cy == BIT_HEIGHT'(FRAME_HEIGHT - 1));
    assign time_reached = counter >= start_time;

    // Pulses are decoded from registered state so they cannot overlap; gating
    // with reset keeps the sender quiet while the state register is being cleared.
    logic fetch, launch, underrun, late_event, error_event;
    assign fetch       = clk_pixel_resetn && (state == ST_IDLE) && sched_enable && !bus.cmd_empty;
    assign launch      = clk_pixel_resetn && (state == ST_WAIT_FRAME) && frame_start && !bus.image_empty;
    assign underrun    = (state == ST_WAIT_FRAME) && frame_start && bus.image_empty;
    assign late_event  = (state == ST_WAIT_TIME) && wait_first && time_reached;
    assign error_event = (state == ST_DECODE) && (opcode == OP_RESERVED);

    assign bus.cmd_rd_en   = fetch;
    assign bus.auto_start  = launch;
    assign bus.image_flush = clk_pixel_resetn && (state == ST_DECODE) && (opcode == OP_FLUSH);
    assign bus.image_reset = clk_pixel_resetn && (state == ST_DECODE) && (opcode == OP_RESET_SENDER);
    assign busy            = (state != ST_IDLE);

    always_ff @(posedge clk_pixel) begin
        if (!clk_pixel_resetn) begin
            state          <= ST_IDLE;
            cmd            <= '0;
            frames_left    <= '0;
            wait_first     <= 1'b0;
            late_flag      <= 1'b0;
            error_flag     <= 1'b0;
            underrun_count <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (fetch) begin
                        cmd   <= bus.cmd_dout[OP_MSB:0];
                        state <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    if (opcode == OP_SHOW) begin
                        wait_first <= 1'b1;
                        state      <= ST_WAIT_TIME;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_WAIT_TIME: begin
                    wait_first <= 1'b0;
                    if (time_reached) state <= ST_WAIT_FRAME;
                end
                ST_WAIT_FRAME: begin
                    if (launch) begin
                        frames_left <= (frame_count == 16'd0) ? 16'd1 : frame_count;
                        state       <= ST_DISPLAY;
                    end
                end
                ST_DISPLAY: begin
                    if (frame_end) begin
                        if (frames_left != 16'd0) frames_left <= frames_left - 16'd1;
                        // frame_count==0 plays until the next command is waiting
                        if (frame_count == 16'd0) begin
                            if (!bus.cmd_empty) state <= ST_IDLE;
                        end else if (frames_left == 16'd1) begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase

            if (late_event)      late_flag <= 1'b1;
            else if (flag_clear) late_flag <= 1'b0;

            if (error_event)     error_flag <= 1'b1;
            else if (flag_clear) error_flag <= 1'b0;

            if (underrun) begin
                if (flag_clear)                       underrun_count <= 16'd1;
                else if (underrun_count != 16'hFFFF) underrun_count <= underrun_count + 16'd1;
            end else if (flag_clear) begin
                underrun_count <= '0;
            end
        end
    end

endmodule

// File: tb/tb_image_frame_scheduler.sv
// tb/tb_image_frame_scheduler.sv - directed self-checking bench for image_frame_scheduler
module tb_image_frame_scheduler;
    import image_sched_pkg::*;

    localparam int FW = 8;
    localparam int FH = 4;

    logic        clk_pixel = 1'b0;
    logic        clk_pixel_resetn = 1'b0;
    logic [63:0] counter = '0;
    logic [11:0] cx = '0;
    logic [10:0] cy = '0;
    logic        sched_enable = 1'b1;
    logic        flag_clear = 1'b0;
    logic        busy, late_flag, error_flag;
    logic [15:0] underrun_count;

    image_frame_scheduler_if bus();

    image_frame_scheduler #(
        .FRAME_WIDTH(FW), .FRAME_HEIGHT(FH), .BIT_WIDTH(12), .BIT_HEIGHT(11)
    ) dut (
        .clk_pixel        (clk_pixel),
        .clk_pixel_resetn (clk_pixel_resetn),
        .counter          (counter),
        .cx               (cx),
        .cy               (cy),
        .bus              (bus),
        .sched_enable     (sched_enable),
        .flag_clear       (flag_clear),
        .busy             (busy),
        .late_flag        (late_flag),
        .error_flag       (error_flag),
        .underrun_count   (underrun_count)
    );

    always #5 clk_pixel = ~clk_pixel;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    logic [127:0] fifo_q[$];
    bit           pop_pending = 0;
    bit           counter_load = 0;
    logic [63:0]  counter_load_val = '0;
    int           cyc = 0;
    int           n_auto, n_flush, n_reset, n_rd, n_overlap, n_auto_off;
    int           auto_cyc, flush_cyc, reset_cyc, rd_cyc;
    logic [63:0]  auto_counter;
    bit           fe_armed = 0;
    int           fe_cyc = -1;

    // Drives raster, timestamp and FIFO model at negedge, samples outputs 3 units later.
    always @(negedge clk_pixel) begin
        if (pop_pending && fifo_q.size() > 0) fifo_q.delete(0);
        pop_pending = 0;
        cyc++;
        if (counter_load) begin
            counter = counter_load_val;
            counter_load = 0;
        end else begin
            counter = counter + 64'd1;
        end
        if (cx == 12'(FW - 1)) begin
            cx = '0;
            cy = (cy == 11'(FH - 1)) ? '0 : cy + 11'd1;
        end else begin
            cx = cx + 12'd1;
        end
        bus.cmd_empty = (fifo_q.size() == 0);
        bus.cmd_dout  = (fifo_q.size() == 0) ? '0 : fifo_q[0];
        #3;
        if (bus.auto_start) begin
            n_auto++; auto_cyc = cyc; auto_counter = counter;
            if (!(cx == 0 && cy == 0)) n_auto_off++;
        end
        if (bus.image_flush) begin n_flush++; flush_cyc = cyc; end
        if (bus.image_reset) begin n_reset++; reset_cyc = cyc; end
        if (bus.cmd_rd_en) begin n_rd++; rd_cyc = cyc; pop_pending = 1; end
        if ((int'(bus.auto_start) + int'(bus.image_flush) + int'(bus.image_reset) + int'(bus.cmd_rd_en)) > 1)
            n_overlap++;
        if (fe_armed && fe_cyc < 0 && !bus.cmd_empty && cx == 12'(FW - 1) && cy == 11'(FH - 1))
            fe_cyc = cyc;
    end

    function automatic logic [127:0] mk_cmd(input logic [63:0] st, input logic [15:0] fc, input logic [1:0] op);
        logic [127:0] c;
        c = '0;
        c[TIME_MSB:TIME_LSB]   = st;
        c[COUNT_MSB:COUNT_LSB] = fc;
        c[OP_MSB:OP_LSB]       = op;
        return c;
    endfunction

    task automatic step_drive();
        @(negedge clk_pixel); #1;
    endtask

    task automatic sample_pt();
        @(negedge clk_pixel); #4;
    endtask

    task automatic clr_mon();
        n_auto = 0; n_flush = 0; n_reset = 0; n_rd = 0; n_overlap = 0; n_auto_off = 0;
        auto_cyc = 0; flush_cyc = 0; reset_cyc = 0; rd_cyc = 0; auto_counter = '0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int k;
        k = 0;
        do begin
            sample_pt();
            k++;
        end while (!(fifo_q.size() == 0 && !busy && !bus.cmd_rd_en) && k < budget);
        check({tag, "_done"}, 64'(k < budget), 1);
    endtask

    task automatic pulse_clear();
        step_drive(); flag_clear = 1'b1;
        step_drive(); flag_clear = 1'b0;
    endtask

    logic [7:0] outs;
    assign outs = {busy, late_flag, error_flag, bus.auto_start, bus.image_flush,
                   bus.image_reset, bus.cmd_rd_en, |underrun_count};

    initial begin
        int k, d;
        bus.image_empty = 1'b0;
        bus.cmd_empty   = 1'b1;
        bus.cmd_dout    = '0;
        clr_mon();

        repeat (3) step_drive();
        clk_pixel_resetn = 1'b1;
        sample_pt();
        check("reset_outputs", 64'(outs), 0);
        check("reset_underrun", 64'(underrun_count), 0);

        // On-time SHOW of two frames
        step_drive();
        clr_mon();
        counter_load_val = 64'd0; counter_load = 1;
        fifo_q.push_back(mk_cmd(64'd1000, 16'd2, 2'd0));
        wait_done(2000, "s1");
        check("s1_auto_count", 64'(n_auto), 1);
        check("s1_auto_not_early", 64'(auto_counter >= 64'd1001), 1);
        check("s1_auto_next_frame", 64'(auto_counter <= 64'd1032), 1);
        check("s1_auto_on_frame_start", 64'(n_auto_off), 0);
        check("s1_two_frames", 64'(cyc - auto_cyc), 64);
        check("s1_late", 64'(late_flag), 0);

        // Late SHOW
        step_drive();
        clr_mon();
        counter_load_val = 64'd500; counter_load = 1;
        fifo_q.push_back(mk_cmd(64'd5, 16'd1, 2'd0));
        wait_done(200, "s2");
        check("s2_late", 64'(late_flag), 1);
        check("s2_auto_count", 64'(n_auto), 1);
        check("s2_auto_on_frame_start", 64'(n_auto_off), 0);
        check("s2_one_frame", 64'(cyc - auto_cyc), 32);
        pulse_clear();
        sample_pt();
        check("s2_late_cleared", 64'(late_flag), 0);

        // Three underruns then playback
        step_drive();
        clr_mon();
        bus.image_empty = 1'b1;
        fifo_q.push_back(mk_cmd(64'd0, 16'd1, 2'd0));
        k = 0;
        do begin sample_pt(); k++; end while (underrun_count != 16'd3 && k < 200);
        check("s3_reach_three", 64'(k < 200), 1);
        d = cyc;
        step_drive();
        bus.image_empty = 1'b0;
        wait_done(200, "s3");
        check("s3_underrun", 64'(underrun_count), 3);
        check("s3_auto_count", 64'(n_auto), 1);
        check("s3_auto_fourth_start", 64'(auto_cyc - d), 31);
        check("s3_auto_on_frame_start", 64'(n_auto_off), 0);

        // FLUSH, RESET_SENDER, reserved back-to-back
        pulse_clear();
        step_drive();
        clr_mon();
        fifo_q.push_back(mk_cmd(64'd0, 16'd0, 2'd1));
        fifo_q.push_back(mk_cmd(64'd0, 16'd0, 2'd2));
        fifo_q.push_back(mk_cmd(64'd0, 16'd0, 2'd3));
        wait_done(100, "s4");
        check("s4_flush_once", 64'(n_flush), 1);
        check("s4_reset_once", 64'(n_reset), 1);
        check("s4_pulse_gap", 64'(reset_cyc - flush_cyc), 2);
        check("s4_error", 64'(error_flag), 1);
        check("s4_no_auto", 64'(n_auto), 0);
        check("s4_pops", 64'(n_rd), 3);
        check("s4_overlap", 64'(n_overlap), 0);
        pulse_clear();
        sample_pt();
        check("s4_error_cleared", 64'(error_flag), 0);

        // Endless SHOW displaced by a later command
        step_drive();
        clr_mon();
        fifo_q.push_back(mk_cmd(64'd0, 16'd0, 2'd0));
        k = 0;
        do begin sample_pt(); k++; end while (n_auto != 1 && k < 100);
        check("s5_started", 64'(k < 100), 1);
        repeat (96) sample_pt();
        check("s5_holds", 64'(busy), 1);
        step_drive();
        fe_cyc = -1; fe_armed = 1;
        fifo_q.push_back(mk_cmd(64'd0, 16'd1, 2'd0));
        wait_done(300, "s5");
        fe_armed = 0;
        check("s5_pop_at_frame_end", 64'(rd_cyc - fe_cyc), 1);
        check("s5_pops", 64'(n_rd), 2);
        check("s5_autos", 64'(n_auto), 2);
        check("s5_overlap", 64'(n_overlap), 0);

        // Clear coincident with underrun, then reset in WAIT_FRAME
        pulse_clear();
        step_drive();
        clr_mon();
        bus.image_empty = 1'b1;
        fifo_q.push_back(mk_cmd(64'd0, 16'd1, 2'd0));
        k = 0;
        do begin sample_pt(); k++; end while (underrun_count != 16'd1 && k < 200);
        check("s6_first_underrun", 64'(k < 200), 1);
        k = 0;
        do begin step_drive(); k++; end while (!(cx == 0 && cy == 0) && k < 40);
        flag_clear = 1'b1;
        step_drive();
        flag_clear = 1'b0;
        #3;
        check("s6_clear_vs_underrun", 64'(underrun_count), 1);
        check("s6_late_cleared", 64'(late_flag), 0);
        check("s6_in_wait", 64'(busy), 1);
        step_drive();
        clk_pixel_resetn = 1'b0;
        step_drive();
        clk_pixel_resetn = 1'b1;
        #3;
        check("s6_reset_outputs", 64'(outs), 0);
        bus.image_empty = 1'b0;
        repeat (40) sample_pt();
        check("s6_no_auto_after_reset", 64'(n_auto), 0);
        check("s6_idle_after_reset", 64'(busy), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
